// File: rtl/seg_pkg.sv
// Shared glyph constants, digit record type and output polarity helper
// for the multiplexed 7-segment scanner.
package seg_pkg;

  // Segment order {dp,g,f,e,d,c,b,a}; dp is merged in by the decoder.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_OFF = '{code: CODE_BLANK, dp: 1'b0};

  function automatic logic [7:0] apply_inv(input logic [7:0] v, input bit inv);
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph decoder for one digit: code + mode + blank + dp -> segments.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] glyph
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (code)
      4'd0:  seg = SEG_0[6:0];
      4'd1:  seg = SEG_1[6:0];
      4'd2:  seg = SEG_2[6:0];
      4'd3:  seg = SEG_3[6:0];
      4'd4:  seg = SEG_4[6:0];
      4'd5:  seg = SEG_5[6:0];
      4'd6:  seg = SEG_6[6:0];
      4'd7:  seg = SEG_7[6:0];
      4'd8:  seg = SEG_8[6:0];
      4'd9:  seg = SEG_9[6:0];
      4'd10: seg = hex_mode ? SEG_A[6:0] : SEG_BLANK[6:0];
      4'd11: seg = hex_mode ? SEG_B[6:0] : SEG_BLANK[6:0];
      4'd12: seg = hex_mode ? SEG_C[6:0] : SEG_BLANK[6:0];
      4'd13: seg = hex_mode ? SEG_D[6:0] : SEG_BLANK[6:0];
      4'd14: seg = hex_mode ? SEG_E[6:0] : SEG_BLANK[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
    if (blank) seg = SEG_BLANK[6:0];
  end

  // dp survives blanking so a lone point can still be shown.
  assign glyph = {dp, seg};

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed DIGITS-wide 7-segment driver with frame-synchronous
// double buffering, hex/decimal glyphs and leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit SEG_INV   = 1'b0,
  parameter bit SEL_INV   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   seg_data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg_led,
  output logic [DIGITS-1:0]     seg_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          tick, wrap, pending, run;

  digit_t [DIGITS-1:0]      in_buf, shad_buf, disp_buf;
  logic   [DIGITS-1:0]      lz_sup, sel_nx;
  logic   [DIGITS-1:0][7:0] glyph_all;
  logic   [7:0]             glyph_cur;

  assign tick = en && (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Per-digit input repack and decoder.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign in_buf[i] = '{code: seg_data[4*i +: 4], dp: dp_in[i]};

    seg_decode u_dec (
      .code    (disp_buf[i].code),
      .hex_mode(hex_mode),
      .blank   (lz_sup[i]),
      .dp      (disp_buf[i].dp),
      .glyph   (glyph_all[i])
    );
  end

  // A digit is suppressed while every digit from the top down to it is 0 or blank;
  // digit 0 is never suppressed so an all-zero value still shows "0".
  always_comb begin
    lz_sup = '0;
    run    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run       = run && ((disp_buf[i].code == 4'd0) || (disp_buf[i].code == CODE_BLANK));
      lz_sup[i] = lz_blank && run;
    end
  end

  assign glyph_cur = glyph_all[idx];

  always_comb begin
    sel_nx = '0;
    for (int i = 0; i < DIGITS; i++)
      sel_nx[i] = (idx == IW'(i)) && (presc >= PW'(BLANK_CYC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= wrap ? '0 : idx + IW'(1);
    end else if (en) begin
      presc <= presc + PW'(1);
    end
  end

  // A load coinciding with the wrap bypasses the shadow and commits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shad_buf <= {DIGITS{DIGIT_OFF}};
      disp_buf <= {DIGITS{DIGIT_OFF}};
      pending  <= 1'b0;
    end else begin
      if (load) shad_buf <= in_buf;
      if (wrap) begin
        if (load)         disp_buf <= in_buf;
        else if (pending) disp_buf <= shad_buf;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_led    <= apply_inv(SEG_BLANK, SEG_INV);
      seg_sel    <= {DIGITS{SEL_INV}};
      frame_done <= 1'b0;
    end else begin
      seg_led    <= apply_inv(en ? glyph_cur : SEG_BLANK, SEG_INV);
      seg_sel    <= (en ? sel_nx : '0) ^ {DIGITS{SEL_INV}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized self-checking bench for seg_scan against a position/frame level model.
module tb_seg_scan;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = D * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, hex_mode = 1'b0, lz_blank = 1'b0, load = 1'b0;
  logic [15:0] seg_data = '0;
  logic [3:0]  dp_in = '0;
  logic [7:0]  seg_led;
  logic [3:0]  seg_sel;
  logic        frame_done;

  seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_INV(1'b0), .SEL_INV(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .hex_mode(hex_mode), .lz_blank(lz_blank),
    .load(load), .seg_data(seg_data), .dp_in(dp_in),
    .seg_led(seg_led), .seg_sel(seg_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: m_pos counts enabled cycles within a frame; digit = m_pos / SD, slot cycle = m_pos % SD.
  int         m_pos;
  logic [3:0] m_code[D], s_code[D];
  logic       m_dp[D], s_dp[D];
  bit         m_pend;
  logic [7:0] exp_led;
  logic [3:0] exp_sel;
  logic       exp_fd;
  logic [7:0] tbl[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};

  function automatic logic [7:0] ref_glyph(int d);
    bit sup = lz_blank && (d != 0);
    logic [3:0] c = m_code[d];
    logic [7:0] g;
    for (int j = d; j < D; j++) if (m_code[j] != 4'd0 && m_code[j] != 4'd15) sup = 0;
    g = (sup || c == 4'd15 || (c >= 4'd10 && !hex_mode)) ? 8'h00 : tbl[c];
    return g | (m_dp[d] ? 8'h80 : 8'h00);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_pend = 0;
    for (int i = 0; i < D; i++) begin m_code[i] = 4'hF; m_dp[i] = 0; s_code[i] = 4'hF; s_dp[i] = 0; end
  endtask

  // One clock: predict the registered outputs from pre-edge state, then advance the model.
  task automatic cyc();
    int  cnt  = m_pos % SD;
    int  di   = m_pos / SD;
    bit  wrap = en && (m_pos == FRAME - 1);
    exp_led = en ? ref_glyph(di) : 8'h00;
    exp_sel = (en && cnt >= BC) ? 4'(1 << di) : 4'h0;
    exp_fd  = wrap;
    if (wrap) begin
      for (int i = 0; i < D; i++)
        if (load) begin m_code[i] = seg_data[4*i +: 4]; m_dp[i] = dp_in[i]; end
        else if (m_pend) begin m_code[i] = s_code[i]; m_dp[i] = s_dp[i]; end
      m_pend = 0;
    end else if (load) m_pend = 1;
    if (load) for (int i = 0; i < D; i++) begin s_code[i] = seg_data[4*i +: 4]; s_dp[i] = dp_in[i]; end
    if (en) m_pos = (m_pos + 1) % FRAME;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    seg_data = d; dp_in = p; load = 1; cyc(); load = 0;
  endtask

  // Advance (unchecked) until the model reaches position p; bounded by one frame.
  task automatic goto_pos(input int p);
    for (int k = 0; k < FRAME && m_pos != p; k++) cyc();
  endtask

  function automatic int sel_digit(logic [3:0] s);
    for (int i = 0; i < D; i++) if (s == 4'(1 << i)) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1; #2;
    n_chk++;
    if (seg_led !== 8'h00 || seg_sel !== 4'h0 || frame_done !== 1'b0)
      $display("FAIL reset_async: led=%h sel=%b fd=%b want 00/0000/0", seg_led, seg_sel, frame_done);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1; rst = 0; model_reset();
    en = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n_chk++;
      if (seg_led !== 8'h00 || seg_sel !== 4'h0 || frame_done !== 1'b0)
        $display("FAIL reset_idle k=%0d: led=%h sel=%b fd=%b want dark", k, seg_led, seg_sel, frame_done);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [7:0] want[D] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    int last_fd = -1, lit = 0;
    lz_blank = 0; hex_mode = 0; en = 1;
    do_load(16'h1234, 4'h0);
    for (int k = 0; k < 56; k++) begin
      cyc();
      n_chk++;
      if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
        $display("FAIL scan k=%0d: led=%h sel=%b fd=%b want %h/%b/%b", k, seg_led, seg_sel, frame_done, exp_led, exp_sel, exp_fd);
      else n_pass++;
      if (k >= 18 && seg_sel != 0) begin
        lit++;
        n_chk++;
        if (sel_digit(seg_sel) < 0 || seg_led !== want[sel_digit(seg_sel)])
          $display("FAIL scan_glyph k=%0d: sel=%b led=%h", k, seg_sel, seg_led);
        else n_pass++;
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          n_chk++;
          if (k - last_fd != FRAME) $display("FAIL frame_period: got %0d want %0d", k - last_fd, FRAME);
          else n_pass++;
        end
        last_fd = k;
      end
    end
    n_chk++;
    if (lit < 20) $display("FAIL scan_lit: lit cycles %0d want >= 20", lit);
    else n_pass++;
  endtask

  task automatic test_lz();
    logic [15:0] vals[2]  = '{16'h0050, 16'h0000};
    logic [7:0]  want[2][D] = '{'{8'h3F, 8'h6D, 8'h00, 8'h00}, '{8'h3F, 8'h00, 8'h00, 8'h00}};
    lz_blank = 1; hex_mode = 0; en = 1;
    for (int v = 0; v < 2; v++) begin
      do_load(vals[v], 4'h0);
      for (int k = 0; k < 36; k++) begin
        cyc();
        n_chk++;
        if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
          $display("FAIL lz v=%0d k=%0d: led=%h sel=%b fd=%b want %h/%b/%b", v, k, seg_led, seg_sel, frame_done, exp_led, exp_sel, exp_fd);
        else n_pass++;
        if (k >= 18 && seg_sel != 0) begin
          n_chk++;
          if (sel_digit(seg_sel) < 0 || seg_led !== want[v][sel_digit(seg_sel)])
            $display("FAIL lz_glyph v=%0d sel=%b led=%h", v, seg_sel, seg_led);
          else n_pass++;
        end
      end
    end
    for (int r = 0; r < 6; r++) begin
      do_load(16'($urandom_range(0, 16'hFFFF) & (r[0] ? 16'h00FF : 16'h0F0F)), 4'($urandom));
      hex_mode = r[1];
      for (int k = 0; k < 34; k++) begin
        cyc();
        n_chk++;
        if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
          $display("FAIL lz_rand r=%0d k=%0d: led=%h sel=%b want %h/%b", r, k, seg_led, seg_sel, exp_led, exp_sel);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hex();
    logic [7:0] want[3][D] = '{'{8'h00, 8'h39, 8'h7C, 8'h77}, '{8'h00, 8'h00, 8'h00, 8'h00},
                               '{8'h80, 8'h00, 8'h00, 8'h00}};
    lz_blank = 0; en = 1;
    for (int v = 0; v < 3; v++) begin
      hex_mode = (v == 0);
      do_load(16'hABCF, (v == 2) ? 4'b0001 : 4'b0000);
      for (int k = 0; k < 36; k++) begin
        cyc();
        n_chk++;
        if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
          $display("FAIL hex v=%0d k=%0d: led=%h sel=%b want %h/%b", v, k, seg_led, seg_sel, exp_led, exp_sel);
        else n_pass++;
        if (k >= 18 && seg_sel != 0) begin
          n_chk++;
          if (sel_digit(seg_sel) < 0 || seg_led !== want[v][sel_digit(seg_sel)])
            $display("FAIL hex_glyph v=%0d sel=%b led=%h", v, seg_sel, seg_led);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_buffer();
    lz_blank = 0; hex_mode = 1; en = 1;
    do_load(16'h1111, 4'h0);
    goto_pos(FRAME - 1); cyc();
    // Mid-frame load must not disturb the current frame.
    goto_pos(5);
    do_load(16'h2222, 4'h0);
    while (m_pos != FRAME - 1) begin
      cyc();
      n_chk++;
      if (seg_sel != 0 && seg_led !== 8'h06) $display("FAIL buf_hold: led=%h want 06", seg_led);
      else if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
        $display("FAIL buf_hold_model: led=%h sel=%b want %h/%b", seg_led, seg_sel, exp_led, exp_sel);
      else n_pass++;
    end
    // Load exactly on the wrap tick: committed directly.
    do_load(16'h3333, 4'h0);
    for (int k = 1; k < FRAME; k++) begin
      cyc();
      n_chk++;
      if (seg_sel != 0 && seg_led !== 8'h4F) $display("FAIL buf_wrap_load k=%0d: led=%h want 4F", k, seg_led);
      else if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
        $display("FAIL buf_wrap_model k=%0d: led=%h sel=%b want %h/%b", k, seg_led, seg_sel, exp_led, exp_sel);
      else n_pass++;
    end
    // Two loads in one frame: the last one wins.
    goto_pos(2); do_load(16'h5555, 4'h0);
    goto_pos(6); do_load(16'h6666, 4'h0);
    goto_pos(FRAME - 1); cyc();
    for (int k = 1; k < FRAME; k++) begin
      cyc();
      n_chk++;
      if (seg_sel != 0 && seg_led !== 8'h7D) $display("FAIL buf_last_wins k=%0d: led=%h want 7D", k, seg_led);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 19) == 0) hex_mode = ~hex_mode;
      load = ($urandom_range(0, 9) == 0);
      seg_data = 16'($urandom); dp_in = 4'($urandom);
      cyc();
      load = 0;
      n_chk++;
      if ({seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
        $display("FAIL random k=%0d: led=%h sel=%b fd=%b want %h/%b/%b", k, seg_led, seg_sel, frame_done, exp_led, exp_sel, exp_fd);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    lz_blank = 0; hex_mode = 0; en = 1;
    do_load(16'h8888, 4'h0);
    goto_pos(FRAME - 1); cyc();
    goto_pos(6);
    do_load(16'h9999, 4'h0);
    #1 rst = 1; #1;
    n_chk++;
    if (seg_led !== 8'h00 || seg_sel !== 4'h0 || frame_done !== 1'b0)
      $display("FAIL rst_mid_async: led=%h sel=%b fd=%b want dark", seg_led, seg_sel, frame_done);
    else n_pass++;
    @(posedge clk); #1; rst = 0; model_reset();
    for (int k = 0; k < 40; k++) begin
      cyc();
      n_chk++;
      if (seg_led !== 8'h00 || {seg_led, seg_sel, frame_done} !== {exp_led, exp_sel, exp_fd})
        $display("FAIL rst_mid k=%0d: led=%h sel=%b fd=%b want %h/%b/%b", k, seg_led, seg_sel, frame_done, exp_led, exp_sel, exp_fd);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_lz();
    test_hex();
    test_buffer();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
